// File: rtl/tdm_pkg.sv
// Shared types and constants for the 2-bit TDM demultiplexer.
// Lane i of the packed output bus starts at bit W*i.
package tdm_pkg;

    localparam int unsigned TDM_W = 2;
    localparam int unsigned TDM_N = 4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } tdm_state_e;

    function automatic int unsigned lane_slice(input int unsigned i, input int unsigned w = TDM_W);
        return w * i;
    endfunction

endpackage

// File: rtl/tdm_lane_reg.sv
// One output lane: a W-bit register loaded only when its write enable is set.
module tdm_lane_reg #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] lane_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
        end else if (en) begin
            lane_q <= d;
        end
    end

    assign q = lane_q;

endmodule

// File: rtl/tdm_demux4.sv
// Registered TDM demultiplexer: routes each input symbol to one of N lanes,
// chosen by an external select or by an sof-aligned frame counter.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned W = TDM_W,
    parameter int unsigned N = TDM_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           din,
    input  logic                   din_valid,
    input  logic                   sof,
    input  logic                   sel_mode,
    input  logic [$clog2(N)-1:0]   sel,
    output logic [N*W-1:0]         y,
    output logic [N-1:0]           lane_wr,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    tdm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     we_d, lane_wr_q;
    logic             done_d, done_q;
    logic             err_d, err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (!sel_mode) begin
            // Addressed mode parks the frame FSM; leaving COLLECT this way is a violation.
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = (state_q == ST_COLLECT);
            if (din_valid) begin
                we_d[sel] = 1'b1;
            end
        end else if (din_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (sof) begin
                        we_d[0] = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (sof) begin
                        // Restart: lanes already written by the aborted frame are kept.
                        err_d   = 1'b1;
                        we_d[0] = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        we_d[cnt_q] = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lane_wr_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_wr_q <= we_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        tdm_lane_reg #(.W(W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (we_d[i]),
            .d     (din),
            .q     (y[lane_slice(i, W) +: W])
        );
    end

    assign lane_wr    = lane_wr_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: addressed writes, auto frames, aborts,
// gaps, mode changes and asynchronous reset in the middle of a frame.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] din;
    logic       din_valid;
    logic       sof;
    logic       sel_mode;
    logic [1:0] sel;
    logic [7:0] y;
    logic [3:0] lane_wr;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    tdm_demux4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .sel_mode   (sel_mode),
        .sel        (sel),
        .y          (y),
        .lane_wr    (lane_wr),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, sample 1 ns after the edge, then return inputs to idle.
    task automatic cycle(input logic v, input logic s, input logic [1:0] d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sof       = 1'b0;
        din       = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0; sel_mode = 1'b0; sel = '0;
        #2;
        n_tests++; if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y got=%h exp=00", y); end
        n_tests++; if (lane_wr !== 4'b0000) begin n_fail++; $display("FAIL reset_lane_wr got=%b exp=0000", lane_wr); end
        n_tests++; if ({frame_done, frame_err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {frame_done, frame_err, busy}); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if ({y, lane_wr, frame_done, frame_err, busy} !== 15'd0) begin n_fail++; $display("FAIL reset_release got=%h exp=0", {y, lane_wr, frame_done, frame_err, busy}); end
    endtask

    task automatic test_addressed();
        sel_mode = 1'b0; sel = 2'd2;
        cycle(1'b1, 1'b1, 2'b11);
        n_tests++; if (y !== 8'h30) begin n_fail++; $display("FAIL addr_y got=%h exp=30", y); end
        n_tests++; if (lane_wr !== 4'b0100) begin n_fail++; $display("FAIL addr_lane_wr got=%b exp=0100", lane_wr); end
        n_tests++; if ({frame_done, frame_err, busy} !== 3'b000) begin n_fail++; $display("FAIL addr_flags got=%b exp=000", {frame_done, frame_err, busy}); end
        cycle(1'b0, 1'b0, 2'b01);
        n_tests++; if (lane_wr !== 4'b0000 || y !== 8'h30) begin n_fail++; $display("FAIL addr_hold got=%b/%h exp=0000/30", lane_wr, y); end
    endtask

    task automatic test_auto_frame();
        sel_mode = 1'b1; sel = 2'd3;
        cycle(1'b1, 1'b1, 2'd1);
        n_tests++; if (y !== 8'h31 || lane_wr !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL auto_first got=%h/%b/%b exp=31/0001/1", y, lane_wr, busy); end
        cycle(1'b1, 1'b0, 2'd2);
        n_tests++; if (lane_wr !== 4'b0010 || frame_done !== 1'b0) begin n_fail++; $display("FAIL auto_second got=%b/%b exp=0010/0", lane_wr, frame_done); end
        cycle(1'b1, 1'b0, 2'd3);
        cycle(1'b1, 1'b0, 2'd0);
        n_tests++; if (y !== 8'h39) begin n_fail++; $display("FAIL auto_y got=%h exp=39", y); end
        n_tests++; if (lane_wr !== 4'b1000 || frame_done !== 1'b1 || frame_err !== 1'b0) begin n_fail++; $display("FAIL auto_done got=%b/%b/%b exp=1000/1/0", lane_wr, frame_done, frame_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL auto_busy got=%b exp=0", busy); end
        cycle(1'b0, 1'b0, 2'd0);
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL auto_done_pulse got=%b exp=0", frame_done); end
    endtask

    task automatic test_no_sof();
        cycle(1'b1, 1'b0, 2'd2);
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL nosof_err got=%b exp=1", frame_err); end
        n_tests++; if (y !== 8'h39 || lane_wr !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL nosof_state got=%h/%b/%b exp=39/0000/0", y, lane_wr, busy); end
        cycle(1'b0, 1'b0, 2'd0);
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL nosof_err_pulse got=%b exp=0", frame_err); end
    endtask

    task automatic test_abort();
        cycle(1'b1, 1'b1, 2'd3);
        cycle(1'b1, 1'b0, 2'd1);
        n_tests++; if (y !== 8'h37) begin n_fail++; $display("FAIL abort_pre_y got=%h exp=37", y); end
        cycle(1'b1, 1'b1, 2'd2);
        n_tests++; if (frame_err !== 1'b1 || lane_wr !== 4'b0001 || busy !== 1'b1 || frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_restart got=%b/%b/%b/%b exp=1/0001/1/0", frame_err, lane_wr, busy, frame_done); end
        n_tests++; if (y !== 8'h36) begin n_fail++; $display("FAIL abort_y got=%h exp=36", y); end
        cycle(1'b1, 1'b0, 2'd0);
        n_tests++; if (lane_wr !== 4'b0010 || frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_cnt got=%b/%b exp=0010/0", lane_wr, frame_err); end
        cycle(1'b1, 1'b0, 2'd1);
        cycle(1'b1, 1'b0, 2'd2);
        n_tests++; if (y !== 8'h92 || frame_done !== 1'b1 || lane_wr !== 4'b1000 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_complete got=%h/%b/%b/%b exp=92/1/1000/0", y, frame_done, lane_wr, busy); end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, (k == 0), 2'd3);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    cycle(1'b0, 1'b0, 2'd0);
                    n_tests++; if (busy !== 1'b1 || lane_wr !== 4'b0000 || frame_done !== 1'b0) begin n_fail++; $display("FAIL gap_k%0d_g%0d got=%b/%b/%b exp=1/0000/0", k, g, busy, lane_wr, frame_done); end
                end
            end
        end
        n_tests++; if (y !== 8'hFF || frame_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL gap_done got=%h/%b/%b exp=ff/1/0", y, frame_done, busy); end
    endtask

    task automatic test_reset_mid_frame();
        cycle(1'b1, 1'b1, 2'd1);
        cycle(1'b1, 1'b0, 2'd2);
        n_tests++; if (y !== 8'hF9 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=%h/%b exp=f9/1", y, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (y !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async got=%h/%b exp=00/0", y, busy); end
        @(negedge clk) rst_n = 1'b1;
        cycle(1'b0, 1'b0, 2'd0);
        n_tests++; if ({lane_wr, frame_done, frame_err, busy} !== 7'd0) begin n_fail++; $display("FAIL rmid_pulses got=%b exp=0", {lane_wr, frame_done, frame_err, busy}); end
        cycle(1'b1, 1'b1, 2'd2);
        n_tests++; if (y !== 8'h02 || lane_wr !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_restart got=%h/%b/%b exp=02/0001/1", y, lane_wr, busy); end
    endtask

    task automatic test_mode_change();
        cycle(1'b1, 1'b0, 2'd1);
        n_tests++; if (y !== 8'h06 || lane_wr !== 4'b0010) begin n_fail++; $display("FAIL mode_pre got=%h/%b exp=06/0010", y, lane_wr); end
        sel_mode = 1'b0; sel = 2'd3;
        cycle(1'b1, 1'b0, 2'd3);
        n_tests++; if (frame_err !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL mode_fall got=%b/%b/%b exp=1/0/0", frame_err, busy, frame_done); end
        n_tests++; if (y !== 8'hC6 || lane_wr !== 4'b1000) begin n_fail++; $display("FAIL mode_addr_wr got=%h/%b exp=c6/1000", y, lane_wr); end
        sel_mode = 1'b1;
        cycle(1'b1, 1'b0, 2'd0);
        n_tests++; if (frame_err !== 1'b1 || lane_wr !== 4'b0000 || y !== 8'hC6) begin n_fail++; $display("FAIL mode_rise got=%b/%b/%h exp=1/0000/c6", frame_err, lane_wr, y); end
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_auto_frame();
        test_no_sof();
        test_abort();
        test_gaps();
        test_reset_mid_frame();
        test_mode_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Registered time-division demultiplexer: the receive-side counterpart of the 4-to-1, 2-bit selector.
- Takes a 2-bit symbol stream and distributes each symbol to one of N output lanes.
- Lane choice comes either from an external select (addressed mode) or from an internal frame counter (auto mode).
- Lane packing on y matches the selector's input bus: lane i occupies y[W*i+W-1:W*i].

Parameters:
- W, 2, symbol/lane width in bits.
- N, 4, number of lanes; power of two, N >= 2.
- CNT_W, $clog2(N), lane-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  W  input symbol.
- din_valid  in  1  symbol present this cycle.
- sof  in  1  start-of-frame marker; meaningful only with din_valid in auto mode.
- sel_mode  in  1  0 = addressed, 1 = auto (frame counter).
- sel  in  CNT_W  target lane in addressed mode; ignored in auto mode.
- y  out  N*W  registered lane outputs, lane i at y[W*i+W-1:W*i].
- lane_wr  out  N  one-hot, one-cycle pulse marking the lane written.
- frame_done  out  1  one-cycle pulse: last lane of an auto frame written.
- frame_err  out  1  one-cycle pulse: protocol violation.
- busy  out  1  high while the FSM is in COLLECT.

Behaviour:
- Reset (async assert, sync-style release): y = 0, lane_wr = 0, frame_done = 0, frame_err = 0, busy = 0, state = IDLE, cnt = 0.
- Latency: all outputs are registered; the effect of a sampled input appears the following cycle.
- Unwritten lanes hold their value indefinitely.
- At most one lane is written per cycle; lane_wr is never multi-hot.

Addressed mode (sel_mode = 0):
- din_valid: lane[sel] <= din; lane_wr[sel] pulses.
- sof is ignored. The FSM is forced to IDLE and cnt = 0.
- frame_done never pulses.

Auto-mode FSM, states IDLE and COLLECT:
- IDLE, din_valid & sof: lane[0] <= din, cnt <= 1, go to COLLECT.
- IDLE, din_valid & !sof: symbol dropped, no lane write, frame_err pulses, stay in IDLE.
- COLLECT, din_valid & !sof: lane[cnt] <= din, cnt <= cnt + 1.
  - If cnt == N-1: frame_done pulses in the same cycle as the lane_wr[N-1] pulse, cnt <= 0, go to IDLE.
- COLLECT, din_valid & sof: frame is aborted and restarted. frame_err pulses, lane[0] <= din, cnt <= 1, stay in COLLECT.
  - Partially written lanes of the aborted frame keep their new values; they are not rolled back.
- COLLECT, no din_valid: hold (gaps are allowed, no timeout).

Mode changes:
- sel_mode falls while in COLLECT: frame_err pulses, go to IDLE, cnt <= 0.
  - A din_valid in that same cycle is handled as addressed mode (written to lane[sel]).
- sel_mode rises: FSM is already in IDLE; the next frame needs sof.

Counter:
- cnt is CNT_W bits.
- Wrap from N-1 to 0 happens only on frame completion; cnt never exceeds N-1.

Reset mid-frame:
- Everything returns to reset values immediately.
- The partial frame is discarded; no frame_done or frame_err pulse is issued.

Decomposition:
- Shared package tdm_pkg:
  - State enum {ST_IDLE, ST_COLLECT}.
  - Default W and N constants.
  - Helper function lane_slice(i) giving the bit offset W*i.
- One natural sub-module, tdm_lane_reg:
  - W-bit register with enable and async active-low reset.
  - Instantiated N times by a generate loop.
  - Top level holds the FSM, the counter, the write-enable decode and the pulse registers.

Test Plan:
- Reset, then addressed mode with sel = 2, din = 2'b11, din_valid = 1 for one cycle -> next cycle y = 8'h30, lane_wr = 4'b0100, no other pulses.
- Auto mode, frame 1/2/3/0 with sof on the first symbol, consecutive cycles -> y = 8'h39 after the 4th, frame_done pulses with lane_wr = 4'b1000, busy deasserts.
- Auto mode, din_valid without sof in IDLE -> frame_err pulse, y unchanged, lane_wr = 0.
- Auto mode, sof, two symbols, then sof again -> frame_err pulse, lane 0 rewritten, cnt = 1, busy stays high; three further symbols complete the frame with frame_done.
- Auto mode, gaps of 3 idle cycles between symbols -> frame still completes correctly, busy stays high throughout the gaps.
- rst_n asserted mid-frame (after 2 symbols), asynchronously between clock edges -> y = 0 and busy = 0 immediately; no pulses; the next sof frame starts at lane 0.
